// File: rtl/elliptic_curve_structs.sv
// Purpose: shared field-width, curve-parameter and arbiter-state definitions.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package elliptic_curve_structs;

    // Width of a field element; every operand and result is P_WIDTH bits.
    localparam int P_WIDTH = 8;

    typedef struct packed {
        logic [P_WIDTH-1:0] p;   // field modulus, operands are always < p
    } curve_params_t;

    localparam curve_params_t params = '{p: 8'd251};

    // Result slot of the shared add/sub arbiter.
    typedef enum logic {
        ST_IDLE = 1'b0,   // no result held
        ST_HOLD = 1'b1    // result held on resp_data, resp_valid one-hot
    } arb_state_t;

endpackage

// File: rtl/mod_addsub_arbiter_add.sv
// Purpose: combinational modular add/subtract, result in [0, p-1].
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller registers the result.
// Ports: a, b  - operands (< p); op - 0 add, 1 subtract; res - (a op b) mod p.
module mod_addsub_arbiter_add
    import elliptic_curve_structs::*;
(
    input  logic [P_WIDTH-1:0] a,
    input  logic [P_WIDTH-1:0] b,
    input  logic               op,
    output logic [P_WIDTH-1:0] res
);

    logic [P_WIDTH:0] sum;
    logic [P_WIDTH:0] diff;

    always_comb begin
        // One extra bit so the carry of a+b and the borrow of a-b are visible.
        sum  = {1'b0, a} + {1'b0, b};
        diff = {1'b0, a} - {1'b0, b};
        res  = '0;
        if (op) begin
            // Borrow means a < b; adding p wraps back into range. The
            // correction only needs the low bits since the true result fits.
            if (diff[P_WIDTH]) begin
                res = diff[P_WIDTH-1:0] + params.p;
            end else begin
                res = diff[P_WIDTH-1:0];
            end
        end else begin
            if (sum >= {1'b0, params.p}) begin
                res = sum[P_WIDTH-1:0] - params.p;
            end else begin
                res = sum[P_WIDTH-1:0];
            end
        end
    end

endmodule

// File: rtl/mod_addsub_arbiter.sv
// Purpose: round-robin arbiter sharing one modular add/sub unit among N_REQ requesters.
// Latency: 1 cycle from request handshake to resp_valid; sustains 1 op/cycle.
// Backpressure: a held result stalls all grants until its owner asserts resp_ready.
// Ports: clk/reset (sync, active-high); req_valid/req_ready/req_a/req_b/req_op per
//        requester; resp_valid (one-hot), resp_ready per requester; shared resp_data;
//        busy while a result is held.
module mod_addsub_arbiter
    import elliptic_curve_structs::*;
#(
    parameter int N_REQ = 4
)
(
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_REQ-1:0]                req_valid,
    output logic [N_REQ-1:0]                req_ready,
    input  logic [N_REQ-1:0][P_WIDTH-1:0]   req_a,
    input  logic [N_REQ-1:0][P_WIDTH-1:0]   req_b,
    input  logic [N_REQ-1:0]                req_op,
    output logic [N_REQ-1:0]                resp_valid,
    input  logic [N_REQ-1:0]                resp_ready,
    output logic [P_WIDTH-1:0]              resp_data,
    output logic                            busy
);

    localparam int PTR_W = $clog2(N_REQ);

    arb_state_t         state_q, state_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic [P_WIDTH-1:0] resp_data_q, resp_data_d;

    logic               slot_free;
    logic               resp_hs;
    logic               grant;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W:0]     cand_sum;
    logic [PTR_W-1:0]   cand;

    logic [P_WIDTH-1:0] op_a;
    logic [P_WIDTH-1:0] op_b;
    logic               op_sel;
    logic [P_WIDTH-1:0] op_res;

    mod_addsub_arbiter_add u_add (
        .a   (op_a),
        .b   (op_b),
        .op  (op_sel),
        .res (op_res)
    );

    always_comb begin
        // resp_valid_q is one-hot, so masking with it ignores resp_ready on
        // every index other than the current owner.
        resp_hs   = |(resp_valid_q & resp_ready);
        slot_free = (state_q == ST_IDLE) || resp_hs;

        // Round-robin search: walk from ptr+N_REQ-1 down to ptr so the
        // candidate closest to ptr is written last and wins.
        gnt_idx  = '0;
        cand_sum = '0;
        cand     = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand_sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
            if (cand_sum >= (PTR_W+1)'(N_REQ)) begin
                cand_sum = cand_sum - (PTR_W+1)'(N_REQ);
            end
            cand = cand_sum[PTR_W-1:0];
            if (req_valid[cand]) begin
                gnt_idx = cand;
            end
        end

        grant = !reset && slot_free && (|req_valid);

        req_ready = '0;
        if (grant) begin
            req_ready[gnt_idx] = 1'b1;
        end

        op_a   = req_a[gnt_idx];
        op_b   = req_b[gnt_idx];
        op_sel = req_op[gnt_idx];

        state_d      = state_q;
        ptr_d        = ptr_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        if (grant) begin
            // A grant always wins over a plain release, so a handshake and a
            // new grant in one cycle stay in HOLD with the fresh result.
            state_d               = ST_HOLD;
            resp_valid_d          = '0;
            resp_valid_d[gnt_idx] = 1'b1;
            resp_data_d           = op_res;
            if (int'(gnt_idx) == N_REQ - 1) begin
                ptr_d = '0;
            end else begin
                ptr_d = gnt_idx + 1'b1;
            end
        end else if ((state_q == ST_HOLD) && resp_hs) begin
            state_d      = ST_IDLE;
            resp_valid_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ptr_q        <= '0;
            resp_valid_q <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign busy       = (state_q == ST_HOLD);

endmodule

// File: tb/tb_mod_addsub_arbiter.sv
module tb_mod_addsub_arbiter;
    import elliptic_curve_structs::*;

    localparam int N = 4;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [N-1:0]              req_valid;
    logic [N-1:0]              req_ready;
    logic [N-1:0][P_WIDTH-1:0] req_a;
    logic [N-1:0][P_WIDTH-1:0] req_b;
    logic [N-1:0]              req_op;
    logic [N-1:0]              resp_valid;
    logic [N-1:0]              resp_ready;
    logic [P_WIDTH-1:0]        resp_data;
    logic                      busy;

    int n_total = 0;
    int n_pass  = 0;

    // Hand-computed results of the round-robin operand table (p = 251).
    logic [7:0] rr_exp [4];
    logic [3:0] rr_gnt [5];

    mod_addsub_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        rr_exp[0] = 8'd150;   // 100 + 50
        rr_exp[1] = 8'd0;     // 200 + 51 = 251 = p
        rr_exp[2] = 8'd241;   // 10 - 20 + 251
        rr_exp[3] = 8'd249;   // 250 + 250 - 251
        rr_gnt[0] = 4'b0001;
        rr_gnt[1] = 4'b0010;
        rr_gnt[2] = 4'b0100;
        rr_gnt[3] = 4'b1000;
        rr_gnt[4] = 4'b0001;

        // Reset with requests pending: nothing may be granted.
        reset      = 1'b1;
        req_valid  = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        req_op     = '0;
        resp_ready = '0;
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        tick();
        tick();
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_resp_data", 32'(resp_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        reset     = 1'b0;
        req_valid = '0;
        #1;

        // Single request: (p-1)+1 mod p = 0.
        req_a[1]  = 8'd250;
        req_b[1]  = 8'd1;
        req_op[1] = 1'b0;
        req_valid = 4'b0010;
        #1;
        chk("single_req_ready", 32'(req_ready), 32'h2);
        tick();
        chk("single_resp_valid", 32'(resp_valid), 32'h2);
        chk("single_resp_data", 32'(resp_data), 32'd0);
        chk("single_busy", 32'(busy), 32'h1);
        req_valid  = '0;
        resp_ready = 4'b0010;
        tick();
        chk("release_resp_valid", 32'(resp_valid), 32'h0);
        chk("release_busy", 32'(busy), 32'h0);
        chk("release_data_held", 32'(resp_data), 32'd0);
        resp_ready = '0;

        // Subtract with borrow (ptr now 2), then back-to-back subtract without borrow.
        req_a[2]  = 8'd0;
        req_b[2]  = 8'd1;
        req_op[2] = 1'b1;
        req_valid = 4'b0100;
        #1;
        chk("sub_borrow_req_ready", 32'(req_ready), 32'h4);
        tick();
        chk("sub_borrow_data", 32'(resp_data), 32'd250);
        req_a[3]   = 8'd5;
        req_b[3]   = 8'd3;
        req_op[3]  = 1'b1;
        req_valid  = 4'b1000;
        resp_ready = 4'b0100;
        #1;
        chk("b2b_req_ready", 32'(req_ready), 32'h8);
        tick();
        chk("b2b_resp_valid", 32'(resp_valid), 32'h8);
        chk("sub_plain_data", 32'(resp_data), 32'd2);
        chk("b2b_busy", 32'(busy), 32'h1);
        req_valid  = '0;
        resp_ready = 4'b1000;
        tick();
        chk("b2b_idle", 32'(busy), 32'h0);

        // Round-robin with everyone requesting and consuming (ptr now 0).
        req_a[0] = 8'd100; req_b[0] = 8'd50;  req_op[0] = 1'b0;
        req_a[1] = 8'd200; req_b[1] = 8'd51;  req_op[1] = 1'b0;
        req_a[2] = 8'd10;  req_b[2] = 8'd20;  req_op[2] = 1'b1;
        req_a[3] = 8'd250; req_b[3] = 8'd250; req_op[3] = 1'b0;
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("rr%0d_req_ready", i), 32'(req_ready), 32'(rr_gnt[i]));
            tick();
            chk($sformatf("rr%0d_resp_valid", i), 32'(resp_valid), 32'(rr_gnt[i]));
            chk($sformatf("rr%0d_resp_data", i), 32'(resp_data), 32'(rr_exp[i % 4]));
        end
        req_valid = '0;
        tick();
        chk("rr_idle", 32'(resp_valid), 32'h0);

        // Backpressure: grant req 2 (ptr 1), owner stalls, others flood.
        req_a[2]   = 8'd7;
        req_b[2]   = 8'd9;
        req_op[2]  = 1'b0;
        req_valid  = 4'b0100;
        resp_ready = '0;
        tick();
        chk("bp_grant_valid", 32'(resp_valid), 32'h4);
        req_valid  = 4'b1111;
        resp_ready = 4'b1011;   // every index except the owner
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("bp%0d_req_ready", i), 32'(req_ready), 32'h0);
            chk($sformatf("bp%0d_busy", i), 32'(busy), 32'h1);
            chk($sformatf("bp%0d_resp_valid", i), 32'(resp_valid), 32'h4);
            chk($sformatf("bp%0d_resp_data", i), 32'(resp_data), 32'd16);
            tick();
        end
        resp_ready = 4'b1111;
        #1;
        chk("bp_release_req_ready", 32'(req_ready), 32'h8);
        tick();
        chk("bp_next_valid", 32'(resp_valid), 32'h8);
        chk("bp_next_data", 32'(resp_data), 32'd249);
        req_valid = '0;
        tick();

        // Wrap: steer ptr to 3 via req 2, then 4'b1001 grants 3 then 0.
        req_valid = 4'b0100;
        tick();
        chk("wrap_setup_valid", 32'(resp_valid), 32'h4);
        req_valid = 4'b1001;
        #1;
        chk("wrap_first_req_ready", 32'(req_ready), 32'h8);
        tick();
        chk("wrap_first_valid", 32'(resp_valid), 32'h8);
        #1;
        chk("wrap_second_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("wrap_second_valid", 32'(resp_valid), 32'h1);
        chk("wrap_second_data", 32'(resp_data), 32'd150);
        req_valid = '0;
        tick();

        // Reset while holding req 2's result (ptr 1 -> grant 2).
        req_valid  = 4'b0100;
        resp_ready = '0;
        tick();
        chk("rsthold_valid", 32'(resp_valid), 32'h4);
        reset = 1'b1;
        #1;
        chk("rsthold_req_ready", 32'(req_ready), 32'h0);
        tick();
        chk("rsthold_resp_valid", 32'(resp_valid), 32'h0);
        chk("rsthold_resp_data", 32'(resp_data), 32'd0);
        chk("rsthold_busy", 32'(busy), 32'h0);
        reset     = 1'b0;
        req_valid = 4'b1111;
        #1;
        chk("rsthold_ptr0_req_ready", 32'(req_ready), 32'h1);
        tick();
        chk("rsthold_ptr0_data", 32'(resp_data), 32'd150);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
